// File: rtl/prbs_os_checker.sv
// prbs_os_checker: PRBS11 ordered-set checker with lock hysteresis and a saturating bit-error count.
// Ports: clk_i receive clock; rst_i async active-high reset; enable_i checker active (low holds IDLE);
//        data_i received word, MSB earliest; clr_cnt_i sync clear of err_cnt_o;
//        os_rec_o / os_err_o one-cycle OS clean/errored pulses; locked_o LOCKED state; err_cnt_o error count.
module prbs_os_checker #(
  parameter int          DATA_W     = 1,
  parameter int          OS_LEN     = 448,
  parameter int          SKIP_BITS  = 28,
  parameter logic [10:0] SEED       = 11'h7FF,
  parameter int          LOCK_CNT   = 4,
  parameter int          UNLOCK_CNT = 2,
  parameter int          ERR_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clr_cnt_i,
  output logic              os_rec_o,
  output logic              os_err_o,
  output logic              locked_o,
  output logic [ERR_W-1:0]  err_cnt_o
);
  localparam int BW = $clog2(OS_LEN);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;
  state_t            state_q;
  logic [10:0]       lfsr_q, lfsr_d;
  logic [BW-1:0]     bidx_q, bidx_d;
  logic [CW-1:0]     mism;
  logic              last, word_bad, os_bad_q, done_q, fin_bad_q;
  logic [GW-1:0]     good_q;
  logic [UW-1:0]     bad_q;
  logic [ERR_W:0]    sum;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              os_rec_q, os_err_q, locked_q;
  // Unrolled LFSR: word bit DATA_W-1 meets the first expected bit; bits inside the skip window never count.
  always_comb begin
    lfsr_d = lfsr_q;
    mism   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if ((data_i[DATA_W-1-i] ^ lfsr_d[10]) && (int'(bidx_q) + i >= SKIP_BITS)) mism = mism + CW'(1);
      lfsr_d = {lfsr_d[9:0], lfsr_d[10] ^ lfsr_d[8]};
    end
  end
  assign last      = bidx_q == BW'(OS_LEN - DATA_W);
  assign word_bad  = mism != '0;
  assign bidx_d    = last ? '0 : bidx_q + BW'(DATA_W);
  assign sum       = {1'b0, err_cnt_q} + (ERR_W + 1)'(mism);
  assign err_cnt_d = clr_cnt_i ? '0 : !enable_i ? err_cnt_q : sum[ERR_W] ? '1 : sum[ERR_W-1:0];
  // The error count survives enable low; only reset or clr_cnt_i clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  end
  // done_q/fin_bad_q capture the verdict on the last-word edge; pulses and lock changes follow one edge later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || !enable_i) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      bidx_q    <= '0;
      os_bad_q  <= 1'b0;
      done_q    <= 1'b0;
      fin_bad_q <= 1'b0;
      good_q    <= '0;
      bad_q     <= '0;
      os_rec_q  <= 1'b0;
      os_err_q  <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      bidx_q    <= bidx_d;
      os_bad_q  <= !last && (os_bad_q || word_bad);
      done_q    <= last;
      fin_bad_q <= os_bad_q || word_bad;
      os_rec_q  <= done_q && !fin_bad_q;
      os_err_q  <= done_q && fin_bad_q;
      case (state_q)
        IDLE: state_q <= HUNT;
        HUNT: if (done_q) begin
          if (fin_bad_q) good_q <= '0;
          else if (good_q == GW'(LOCK_CNT - 1)) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            good_q   <= '0;
            bad_q    <= '0;
          end else good_q <= good_q + GW'(1);
        end
        default: if (done_q) begin
          if (!fin_bad_q) bad_q <= '0;
          else if (bad_q == UW'(UNLOCK_CNT - 1)) begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            good_q   <= '0;
            bad_q    <= '0;
          end else bad_q <= bad_q + UW'(1);
        end
      endcase
    end
  end
  assign os_rec_o  = os_rec_q;
  assign os_err_o  = os_err_q;
  assign locked_o  = locked_q;
  assign err_cnt_o = err_cnt_q;
endmodule

// File: doc/prbs_os_checker.md
# prbs_os_checker

Parametrised PRBS11 ordered-set receiver/checker for the USB4 logical layer receive path. It is the multi-bit, lock-tracking successor to the single-bit Gen4 SLOS receiver. It sits after lane deskew and compares each incoming DATA_W-bit word against a locally generated PRBS11 sequence. It reports per-ordered-set pass/fail, maintains a lock state with hysteresis, and accumulates a saturating bit-error count.

## Interface
- DATA_W, 1: bits received per clock; legal values 1, 2, 4, 8.
- OS_LEN, 448: ordered-set length in bits; must be a multiple of DATA_W.
- SKIP_BITS, 28: leading bits of each OS excluded from error checking.
- SEED, 11'h7FF: LFSR seed (11'h7FF lane 0, 11'h770 lane 1).
- LOCK_CNT, 4: consecutive clean OSs required to enter LOCKED.
- UNLOCK_CNT, 2: consecutive errored OSs required to leave LOCKED.
- ERR_W, 16: width of err_cnt.
- clk  in  1  receive clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  checker active; low holds the block in IDLE.
- data_in  in  DATA_W  received bits; data_in[DATA_W-1] is the earliest bit.
- clr_cnt  in  1  synchronous clear of err_cnt.
- os_rec  out  1  one-cycle pulse: previous OS completed with zero checked errors.
- os_err  out  1  one-cycle pulse: previous OS completed with ≥1 checked error.
- locked  out  1  high in LOCKED state.
- err_cnt  out  ERR_W  saturating count of mismatched checked bits.

## Operation
- LFSR: 11 bits, x^11+x^9+1. Expected bit = lfsr[10]. Per-bit step: lfsr <= {lfsr[9:0], lfsr[10]^lfsr[8]}. Per cycle, DATA_W steps are unrolled. Word bit DATA_W-1 is compared against the first expected bit.
- The LFSR is loaded with SEED on reset and whenever enable is low. It free-runs across OS boundaries and is never reseeded mid-stream.
- Bit counter bidx runs 0..OS_LEN-1 and wraps to 0. The first enabled cycle carries bits 0..DATA_W-1 of OS #0. No data-driven alignment is performed; upstream guarantees alignment at enable rise.
- Checked bit: bidx+i ≥ SKIP_BITS. Per-cycle mismatch count = popcount of mismatches on checked bits (0..DATA_W).
- os_bad flag accumulates any checked mismatch within the current OS. It is cleared at the OS start.
- err_cnt += mismatch count, saturating at 2^ERR_W-1. clr_cnt takes priority: on the same cycle err_cnt becomes 0 and that cycle's mismatches are dropped. err_cnt holds across enable low; only reset or clr_cnt clears it.
- State machine, evaluated at each OS completion:
  - IDLE: entered on reset or enable low. Counters, good_run, bad_run and os_bad are cleared. Goes to HUNT on the first enabled cycle.
  - HUNT: a clean OS increments good_run; an errored OS sets good_run=0. When good_run reaches LOCK_CNT, go to LOCKED with bad_run=0.
  - LOCKED: an errored OS increments bad_run; a clean OS sets bad_run=0. When bad_run reaches UNLOCK_CNT, go to HUNT with good_run=0.
- enable falling mid-OS aborts the OS: no os_rec or os_err pulse, immediate return to IDLE, locked deasserts on the next edge.

## Timing
- All outputs are registered. Reset values: os_rec=0, os_err=0, locked=0, err_cnt=0, state=IDLE, lfsr=SEED, bidx=0.
- The OS's last word is sampled on edge N (cycle index OS_LEN/DATA_W − 1 from enable rise). On edge N+1, exactly one of os_rec/os_err pulses for one cycle.
- locked changes on the same edge as the os_rec/os_err pulse that triggers the transition.
- err_cnt updates on the edge following the errored word (1-cycle latency).
- Back-to-back OSs produce one pulse every OS_LEN/DATA_W cycles, with no gap cycles.
- Asserting reset mid-operation clears everything asynchronously. Operation resumes at OS bit 0 on the first enabled edge after reset release.

## Test plan
- Reset/idle: assert reset with enable=1 → all outputs 0. Hold enable=0 for 1000 cycles → no pulses, locked=0.
- Clean stream, DATA_W=1, SEED=7FF: drive the correct PRBS for 4 OSs → os_rec pulses at cycles 448, 896, 1344, 1792; locked rises with the 4th pulse; err_cnt=0.
- Error placement, DATA_W=1: flip bit 10 of OS #0 → os_rec (skip window); flip bits 100 and 101 of OS #1 → os_err, err_cnt=2.
- Hysteresis: after lock, corrupt one OS, then one clean, then two corrupt → locked stays high until the second consecutive os_err, then drops.
- Width/seed variant, DATA_W=8, SEED=770: clean stream → os_rec every 56 cycles. Flip all 8 bits of word 10 → err_cnt=8. clr_cnt together with a mismatch → err_cnt=0.
- Abort: drop enable at bit 200 of OS #2 → no pulse for OS #2, locked=0 next cycle. Re-enable → first pulse 448 cycles later.
